// File: rtl/div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit: one restoring step per cycle, 33-cycle latency.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the RUN phase and completes in one cycle.
module div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  rd_in,
    input  logic        kill,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  rd_out
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [4:0]  rd_q, rd_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        dz_q, dz_d;
    logic [31:0] a_raw_q, a_raw_d;
    logic [31:0] div_q, div_d;
    logic [31:0] quo_q, quo_d;
    logic [32:0] rem_q, rem_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] res_hold_q, res_hold_d;
    logic [4:0]  rd_hold_q, rd_hold_d;

    logic        signed_op;
    logic        a_neg;
    logic        b_neg;
    logic [32:0] rem_shift;
    logic [33:0] diff;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] final_res;

    // op[0]=0 selects the signed variants (DIV, REM)
    assign signed_op = ~op[0];
    assign a_neg     = signed_op & a[31];
    assign b_neg     = signed_op & b[31];

    assign rem_shift = {rem_q[31:0], quo_q[31]};
    assign diff      = {1'b0, rem_shift} - {2'b00, div_q};

    assign quo_fix   = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
    assign rem_fix   = neg_rem_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
    // Zero divisor is decided by the accept-time flag, independent of the datapath
    assign final_res = dz_q ? (op_q[1] ? a_raw_q : 32'hFFFF_FFFF)
                            : (op_q[1] ? rem_fix : quo_fix);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rd_d       = rd_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        dz_d       = dz_q;
        a_raw_d    = a_raw_q;
        div_d      = div_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        res_hold_d = res_hold_q;
        rd_hold_d  = rd_hold_q;

        case (state_q)
            IDLE: begin
                if (start && !kill) begin
                    op_d      = op;
                    rd_d      = rd_in;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    dz_d      = (b == 32'd0);
                    a_raw_d   = a;
                    quo_d     = a_neg ? (~a + 32'd1) : a;
                    div_d     = b_neg ? (~b + 32'd1) : b;
                    rem_d     = 33'd0;
                    cnt_d     = 6'd0;
`ifdef DIV_ZERO_FAST_EN
                    state_d   = (b == 32'd0) ? DONE : RUN;
`else
                    state_d   = RUN;
`endif
                end
            end
            RUN: begin
                rem_d = diff[33] ? rem_shift : diff[32:0];
                quo_d = {quo_q[30:0], ~diff[33]};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                res_hold_d = final_res;
                rd_hold_d  = rd_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (kill) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= 2'd0;
            rd_q       <= 5'd0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            a_raw_q    <= 32'd0;
            div_q      <= 32'd0;
            quo_q      <= 32'd0;
            rem_q      <= 33'd0;
            cnt_q      <= 6'd0;
            res_hold_q <= 32'd0;
            rd_hold_q  <= 5'd0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            dz_q       <= dz_d;
            a_raw_q    <= a_raw_d;
            div_q      <= div_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            res_hold_q <= res_hold_d;
            rd_hold_q  <= rd_hold_d;
        end
    end

    // Outputs show the live result in DONE and the last delivered one otherwise
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = done ? final_res : res_hold_q;
    assign rd_out = done ? rd_q : rd_hold_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, signed/unsigned results, zero divisor, overflow, kill.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd_in;
    logic        kill;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int errors = 0;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    div_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .rd_in  (rd_in),
        .kill   (kill),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request and follow it to completion, checking result, rd, latency and busy length
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input logic [4:0] r,
                         input logic [31:0] exp_res, input int exp_lat);
        int lat;
        int busy_cnt;
        bit got;
        lat = 0;
        busy_cnt = 0;
        got = 1'b0;
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv; rd_in = r;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= 60 && !got; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                lat = i;
                got = 1'b1;
                chk({tag, "_result"}, result, exp_res);
                chk({tag, "_rd"}, {27'd0, rd_out}, {27'd0, r});
            end
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_busy_cycles"}, busy_cnt, exp_lat);
        @(negedge clk);
        chk({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
        chk({tag, "_result_hold"}, result, exp_res);
        $display("op %s a=%h b=%h -> result=%h rd=%0d latency=%0d", tag, av, bv, result, rd_out, lat);
    endtask

    initial begin
        int ndone;
        logic [31:0] last_res;
        logic [4:0]  last_rd;

        reset = 1'b1; start = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0; rd_in = 5'd0; kill = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_rd", {27'd0, rd_out}, 32'd0);
        reset = 1'b0;

        do_op("divu_100_7",  2'b01, 32'd100,       32'd7,         5'd5,  32'd14,        33);
        do_op("rem_m100_7",  2'b10, 32'hFFFFFF9C,  32'd7,         5'd6,  32'hFFFFFFFE,  33);
        do_op("div_m100_7",  2'b00, 32'hFFFFFF9C,  32'd7,         5'd7,  32'hFFFFFFF2,  33);
        do_op("div_ovf",     2'b00, 32'h80000000,  32'hFFFFFFFF,  5'd8,  32'h80000000,  33);
        do_op("rem_ovf",     2'b10, 32'h80000000,  32'hFFFFFFFF,  5'd9,  32'h00000000,  33);
        do_op("div_m5_0",    2'b00, 32'hFFFFFFFB,  32'd0,         5'd10, 32'hFFFFFFFF,  ZLAT);
        do_op("remu_1234_0", 2'b11, 32'h00001234,  32'd0,         5'd11, 32'h00001234,  ZLAT);
        do_op("remu_big",    2'b11, 32'hFFFFFFFF,  32'd10,        5'd12, 32'd5,         33);

        // Second start mid-RUN must be ignored
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd100; b = 32'd7; rd_in = 5'd3;
        @(posedge clk);
        #1 start = 1'b0;
        ndone = 0; last_res = 32'd0; last_rd = 5'd0;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                last_res = result;
                last_rd = rd_out;
            end
            if (i == 10) begin
                start = 1'b1; op = 2'b00; a = 32'd50; b = 32'd5; rd_in = 5'd9;
            end
            if (i == 11) start = 1'b0;
        end
        chk("b2b_done_count", ndone, 32'd1);
        chk("b2b_result", last_res, 32'd14);
        chk("b2b_rd", {27'd0, last_rd}, 32'd3);
        $display("op b2b done_count=%0d result=%h rd=%0d", ndone, last_res, last_rd);

        // Kill during RUN aborts with no done
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd1000; b = 32'd10; rd_in = 5'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        chk("kill_busy", {31'd0, busy}, 32'd0);
        chk("kill_done", {31'd0, done}, 32'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("kill_no_done", ndone, 32'd0);
        $display("op kill busy=%0d done_count=%0d", busy, ndone);

        // Kill and start together in IDLE: nothing accepted
        @(negedge clk);
        start = 1'b1; kill = 1'b1; op = 2'b01; a = 32'd8; b = 32'd2; rd_in = 5'd4;
        @(posedge clk);
        #1 begin start = 1'b0; kill = 1'b0; end
        @(negedge clk);
        chk("kill_start_busy", {31'd0, busy}, 32'd0);
        $display("op kill_start busy=%0d", busy);

        do_op("divu_9_3", 2'b01, 32'd9, 32'd3, 5'd2, 32'd3, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
